// File: rtl/disp_scan_mux.sv
// Self-scanning display multiplexer: holds a tear-free shadow copy of the digit words and
// steps one digit at a time onto a shared digit bus, with anode enables and a frame pulse.
module disp_scan_mux #(
  parameter int NUM_DIGITS    = 8,
  parameter int DATA_W        = 4,
  parameter int PRESCALE      = 100000,
  parameter int AN_ACTIVE_LOW = 1,
  localparam int SEL_W = $clog2(NUM_DIGITS),
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         load,
  input  logic [NUM_DIGITS*DATA_W-1:0] d,
  input  logic [NUM_DIGITS-1:0]        blank,
  output logic [DATA_W-1:0]            Y,
  output logic [SEL_W-1:0]             sel,
  output logic [NUM_DIGITS-1:0]        an,
  output logic                         frame_done
);

  logic [CNT_W-1:0]             cnt_r;
  logic [SEL_W-1:0]             sel_r;
  logic                         frame_done_r;
  logic [NUM_DIGITS*DATA_W-1:0] shadow_data_r;
  logic [NUM_DIGITS-1:0]        shadow_blank_r;
  logic [NUM_DIGITS*DATA_W-1:0] pend_data_r;
  logic [NUM_DIGITS-1:0]        pend_blank_r;
  logic                         pend_r;

  logic                         tick_s;
  logic                         wrap_s;
  logic                         xfer_s;
  logic                         cur_blank_s;
  logic [DATA_W-1:0]            cur_data_s;
  logic [NUM_DIGITS-1:0]        an_on_s;

  // Shadow refreshes only at a frame boundary while scanning; when stalled it follows at once.
  always_comb begin
    tick_s = en && (cnt_r == CNT_W'(PRESCALE - 1));
    wrap_s = tick_s && (sel_r == SEL_W'(NUM_DIGITS - 1));
    xfer_s = wrap_s || !en;
  end

  // Prescaler, digit counter and frame pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r        <= {CNT_W{1'b0}};
      sel_r        <= {SEL_W{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= wrap_s;
      if (tick_s) begin
        cnt_r <= {CNT_W{1'b0}};
        sel_r <= wrap_s ? {SEL_W{1'b0}} : sel_r + SEL_W'(1);
      end else if (en) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Pending capture and shadow transfer; a load on the transfer edge bypasses pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_data_r  <= {(NUM_DIGITS*DATA_W){1'b0}};
      shadow_blank_r <= {NUM_DIGITS{1'b1}};
      pend_data_r    <= {(NUM_DIGITS*DATA_W){1'b0}};
      pend_blank_r   <= {NUM_DIGITS{1'b0}};
      pend_r         <= 1'b0;
    end else if (xfer_s && load) begin
      shadow_data_r  <= d;
      shadow_blank_r <= blank;
      pend_r         <= 1'b0;
    end else if (xfer_s && pend_r) begin
      shadow_data_r  <= pend_data_r;
      shadow_blank_r <= pend_blank_r;
      pend_r         <= 1'b0;
    end else if (load) begin
      pend_data_r    <= d;
      pend_blank_r   <= blank;
      pend_r         <= 1'b1;
    end
  end

  // Digit bus and anode drive follow the registered select with no added latency.
  always_comb begin
    cur_blank_s = shadow_blank_r[sel_r];
    cur_data_s  = shadow_data_r[int'(sel_r)*DATA_W +: DATA_W];
    an_on_s     = {NUM_DIGITS{1'b0}};
    if (cur_blank_s) begin
      Y = {DATA_W{1'b0}};
    end else begin
      Y = cur_data_s;
    end
    if (en && !cur_blank_s) begin
      an_on_s[sel_r] = 1'b1;
    end else begin
      an_on_s = {NUM_DIGITS{1'b0}};
    end
    if (AN_ACTIVE_LOW != 0) begin
      an = ~an_on_s;
    end else begin
      an = an_on_s;
    end
  end

  assign sel        = sel_r;
  assign frame_done = frame_done_r;

endmodule
